// File: rtl/ps2_rx_if.sv
// ----------------------------------------------------------------------------
// ps2_rx_if : byte-side bus of the PS/2 receiver.
//
// Carries the show-ahead FIFO read port and the error strobes between the
// receiver (slave modport) and the core keyboard/mouse logic (master modport).
//   rx_rd       master -> slave  pop request, ignored while rx_valid = 0
//   rx_data     slave  -> master head-of-FIFO byte, meaningful while rx_valid
//   rx_valid    slave  -> master FIFO not empty
//   rx_count    slave  -> master number of bytes held (0 .. 2**FIFO_BITS)
//   parity_err  slave  -> master 1-cycle pulse, frame dropped for bad parity
//   frame_err   slave  -> master 1-cycle pulse, stop bit 0 or timeout abort
//   overflow    slave  -> master 1-cycle pulse, good byte dropped (FIFO full)
// FIFO_BITS must match the FIFO_BITS of the attached ps2_rx instance.
// ----------------------------------------------------------------------------
interface ps2_rx_if #(
  parameter int FIFO_BITS = 2
);
  logic                 rx_rd;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [FIFO_BITS:0]   rx_count;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overflow;

  modport master (
    output rx_rd,
    input  rx_data, rx_valid, rx_count, parity_err, frame_err, overflow
  );

  modport slave (
    input  rx_rd,
    output rx_data, rx_valid, rx_count, parity_err, frame_err, overflow
  );
endinterface

// File: rtl/ps2_rx.sv
// ----------------------------------------------------------------------------
// ps2_rx : core-side PS/2 receiver with a small show-ahead FIFO.
//
// Oversamples the asynchronous PS/2 clock/data lines in the clk domain,
// debounces the PS/2 clock, turns its falling edges into one-cycle strobes and
// deserialises 11-bit frames (start 0, 8 data bits LSB first, odd parity,
// stop 1). Good bytes go into a 2**FIFO_BITS deep FIFO whose head is always
// presented on rx.rx_data.
//
// Ports:
//   clk       core clock (>= 1 MHz), rising edge
//   reset_n   asynchronous active-low reset, released synchronously upstream
//   ps2_clk   PS/2 clock line (idle high), asynchronous to clk
//   ps2_data  PS/2 data line, asynchronous to clk
//   rx        ps2_rx_if.slave : FIFO read port and error pulses
//
// Parameters:
//   FILTER_LEN  consecutive differing samples before the filtered clock
//               follows the synchronised line (1..15)
//   TIMEOUT     clk cycles without a filtered fall mid-frame before abort
//   FIFO_BITS   log2 of FIFO depth
// ----------------------------------------------------------------------------
module ps2_rx #(
  parameter int          FILTER_LEN = 4,
  parameter logic [15:0] TIMEOUT    = 16'd8000,
  parameter int          FIFO_BITS  = 2
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    ps2_clk,
  input  logic    ps2_data,
  ps2_rx_if.slave rx
);

  localparam int                 DEPTH     = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] FULL_CNT  = (FIFO_BITS + 1)'(DEPTH);
  localparam logic [3:0]         FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0]        TOUT_LAST = TIMEOUT - 16'd1;

  // --------------------------------------------------------------------------
  // Two-flop synchronisers, bit 0 = ps2_clk, bit 1 = ps2_data. Both reset to
  // the idle-high line level so no spurious edge is seen after reset.
  // --------------------------------------------------------------------------
  logic [1:0] pin_in;
  logic [1:0] sync_bits;

  assign pin_in = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_bits[gi] = sync_reg;
    end
  endgenerate

  logic clk_sync;
  logic data_sync;

  assign clk_sync  = sync_bits[0];
  assign data_sync = sync_bits[1];

  // --------------------------------------------------------------------------
  // Clock filter: the filtered clock only follows the synchronised line after
  // FILTER_LEN consecutive differing samples; any agreeing sample restarts
  // the count, so short glitches never reach the edge detector.
  // --------------------------------------------------------------------------
  logic [3:0] filt_cnt_reg;
  logic       filt_clk_reg;
  logic       filt_clk_d_reg;
  logic       fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt_reg   <= 4'd0;
      filt_clk_reg   <= 1'b1;
      filt_clk_d_reg <= 1'b1;
    end else begin
      filt_clk_d_reg <= filt_clk_reg;
      if (clk_sync != filt_clk_reg) begin
        if (filt_cnt_reg == FILT_LAST) begin
          filt_clk_reg <= clk_sync;
          filt_cnt_reg <= 4'd0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 4'd1;
        end
      end else begin
        filt_cnt_reg <= 4'd0;
      end
    end
  end

  // One-cycle strobe in the cycle after the filtered clock went low.
  assign fall = filt_clk_d_reg & ~filt_clk_reg;

  // --------------------------------------------------------------------------
  // Frame state machine, advancing only on fall.
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic        parity_reg, parity_next;
  logic [15:0] tout_reg;
  logic        push_reg, push_next;
  logic [7:0]  push_byte_reg;
  logic        frame_err_c;
  logic        parity_err_c;
  logic        parity_ok;

  // Odd parity: data ones plus the parity bit must be odd.
  assign parity_ok = ^{shift_reg, parity_reg};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      shift_reg     <= 8'd0;
      bit_cnt_reg   <= 4'd0;
      parity_reg    <= 1'b0;
      tout_reg      <= 16'd0;
      push_reg      <= 1'b0;
      push_byte_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      push_reg    <= push_next;
      if (push_next) begin
        push_byte_reg <= shift_reg;
      end
      // Watchdog only runs while a frame is in flight; every fall restarts it.
      if (fall || state_reg == IDLE) begin
        tout_reg <= 16'd0;
      end else begin
        tout_reg <= tout_reg + 16'd1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    push_next    = 1'b0;
    frame_err_c  = 1'b0;
    parity_err_c = 1'b0;

    if (fall) begin
      unique case (state_reg)
        IDLE: begin
          if (!data_sync) begin
            state_next   = DATA;
            bit_cnt_next = 4'd0;
          end
        end
        DATA: begin
          shift_next   = {data_sync, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == 4'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_next = data_sync;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // A bad stop bit outranks a parity error: report framing only.
          if (!data_sync) begin
            frame_err_c = 1'b1;
          end else if (!parity_ok) begin
            parity_err_c = 1'b1;
          end else begin
            push_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE && tout_reg == TOUT_LAST) begin
      // Line stalled mid-frame: abandon the partial byte.
      state_next  = IDLE;
      frame_err_c = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO. rx_data is a registered copy of the entry the read
  // pointer will address after this edge, bypassing the write data when the
  // byte being written is the one that becomes the head.
  // --------------------------------------------------------------------------
  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wptr_reg;
  logic [FIFO_BITS-1:0] rptr_reg;
  logic [FIFO_BITS-1:0] rptr_next;
  logic [FIFO_BITS:0]   count_reg;
  logic [7:0]           head_reg, head_next;
  logic                 full;
  logic                 pop;
  logic                 wr_en;
  logic                 overflow_c;

  assign full       = (count_reg == FULL_CNT);
  assign pop        = rx.rx_rd && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en      = push_reg && (!full || pop);
  assign overflow_c = push_reg && full && !pop;
  assign rptr_next  = rptr_reg + FIFO_BITS'(pop);

  always_comb begin
    head_next = mem[rptr_next];
    if (wr_en && wptr_reg == rptr_next) begin
      head_next = push_byte_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_reg] <= push_byte_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      head_reg  <= 8'd0;
    end else begin
      rptr_reg <= rptr_next;
      head_reg <= head_next;
      if (wr_en) begin
        wptr_reg <= wptr_reg + FIFO_BITS'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + (FIFO_BITS + 1)'(1);
        2'b01:   count_reg <= count_reg - (FIFO_BITS + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rx.rx_data    = head_reg;
  assign rx.rx_valid   = (count_reg != '0);
  assign rx.rx_count   = count_reg;
  assign rx.parity_err = parity_err_c;
  assign rx.frame_err  = frame_err_c;
  assign rx.overflow   = overflow_c;

endmodule

// File: tb/tb_ps2_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx : directed self-checking bench for ps2_rx.
//
// A byte-queue model of the FIFO plus expected error-pulse totals is updated
// by the frame stimulus from the frame-format rules; a negedge compare process
// checks count/valid/head and pulse totals against it on every settled cycle.
// Literal expectations pin the model at key points.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_rx;

  localparam int          FL   = 4;
  localparam logic [15:0] TO   = 16'd8000;
  localparam int          FB   = 2;
  localparam int          HALF = 166;   // ~12 kHz PS/2 clock at 4 MHz clk

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  always #125 clk = ~clk;   // 4 MHz

  ps2_rx_if #(.FIFO_BITS(FB)) bus ();

  ps2_rx #(
    .FILTER_LEN(FL),
    .TIMEOUT   (TO),
    .FIFO_BITS (FB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx      (bus.slave)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int         n_perr = 0, n_ferr = 0, n_ovf = 0;
  int         cyc = 0;
  int         last_fall_cyc = 0;
  int         ferr_cyc = 0;
  bit         settled = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Compare process: count pulses every cycle, compare against the model
  // whenever no frame is in flight.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.parity_err) n_perr++;
      if (bus.frame_err) begin
        n_ferr++;
        ferr_cyc = cyc;
      end
      if (bus.overflow) n_ovf++;
      if (settled) begin
        check("cmp_count", int'(bus.rx_count), exp_q.size());
        check("cmp_valid", int'(bus.rx_valid), int'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("cmp_head", int'(bus.rx_data), int'(exp_q[0]));
        check("cmp_parity_err", n_perr, exp_perr);
        check("cmp_frame_err", n_ferr, exp_ferr);
        check("cmp_overflow", n_ovf, exp_ovf);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PS/2 bit: data changes mid high phase, then a full low half-period.
  task automatic ps2_bit(input logic v, input bit glitch, input bit pop_here);
    wait_cyc(HALF / 2 - 4);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(2);
    end else begin
      wait_cyc(4);
    end
    ps2_data = v;
    wait_cyc(HALF - HALF / 2);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    if (pop_here) begin
      // Pin fall -> push takes 2 sync + FL filter + 1 decode + 1 write edges;
      // hold rx_rd across exactly that write edge.
      wait_cyc(FL + 3);
      check("popfull_head", int'(bus.rx_data), 8'h01);
      check("popfull_count", int'(bus.rx_count), 4);
      bus.rx_rd = 1'b1;
      wait_cyc(1);
      bus.rx_rd = 1'b0;
      wait_cyc(HALF - FL - 4);
    end else begin
      wait_cyc(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  // Send the first nbits of a frame; full frames also update the model.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                            input int nbits, input int glitch_bit, input bit pop_at_stop);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    settled = 1'b0;
    for (int i = 0; i < nbits; i++) ps2_bit(bits[i], i == glitch_bit, pop_at_stop && i == 10);
    wait_cyc(HALF / 2);
    ps2_data = 1'b1;
    $display("frame 0x%02h par_flip=%0d stop=%0d bits=%0d", b, par_flip, stop_bit, nbits);
    if (nbits == 11) begin
      if (!stop_bit) exp_ferr++;
      else if (par_flip) exp_perr++;
      else if (pop_at_stop) begin
        void'(exp_q.pop_front());
        exp_q.push_back(b);
      end else if (exp_q.size() == (1 << FB)) exp_ovf++;
      else exp_q.push_back(b);
      wait_cyc(4);
      settled = 1'b1;
    end
  endtask

  task automatic pop_byte(input logic [7:0] lit);
    check("pop_literal", int'(bus.rx_data), int'(lit));
    bus.rx_rd = 1'b1;
    wait_cyc(1);
    bus.rx_rd = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    $display("pop 0x%02h", lit);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(bus.rx_valid), 0);
    check({tag, "_count"}, int'(bus.rx_count), 0);
    check({tag, "_data"}, int'(bus.rx_data), 0);
    check({tag, "_perr"}, int'(bus.parity_err), 0);
    check({tag, "_ferr"}, int'(bus.frame_err), 0);
    check({tag, "_ovf"}, int'(bus.overflow), 0);
  endtask

  initial begin
    #(99_000 * 250);
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int ferr_before;
    bus.rx_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    wait_cyc(5);
    settled = 1'b1;

    // Single byte, then pop to empty; pop while empty has no effect.
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, 1'b0);
    check("t1_data", int'(bus.rx_data), 8'h1C);
    check("t1_count", int'(bus.rx_count), 1);
    pop_byte(8'h1C);
    check("t1_valid_after_pop", int'(bus.rx_valid), 0);
    bus.rx_rd = 1'b1;
    wait_cyc(3);
    bus.rx_rd = 1'b0;
    check("underflow_count", int'(bus.rx_count), 0);
    $display("rd while empty");

    // Two bytes back to back.
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 11, -1, 1'b0);
    check("t2_count", int'(bus.rx_count), 2);
    check("t2_head", int'(bus.rx_data), 8'hF0);
    pop_byte(8'hF0);
    check("t2_next", int'(bus.rx_data), 8'h5A);
    pop_byte(8'h5A);

    // Bad parity, bad stop, and both.
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1, 1'b0);
    check("t3_perr_total", n_perr, 1);
    check("t3_count", int'(bus.rx_count), 0);
    send_frame(8'h1C, 1'b0, 1'b0, 11, -1, 1'b0);
    check("t3_ferr_total", n_ferr, 1);
    send_frame(8'h1C, 1'b1, 1'b0, 11, -1, 1'b0);
    check("t3_both_ferr", n_ferr, 2);
    check("t3_both_perr", n_perr, 1);

    // Overflow on the 5th byte, then push while full with a pop in the same cycle.
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b1, 11, -1, 1'b0);
    check("t4_count", int'(bus.rx_count), 4);
    check("t4_ovf_total", n_ovf, 1);
    check("t4_head", int'(bus.rx_data), 8'h01);
    send_frame(8'h06, 1'b0, 1'b1, 11, -1, 1'b1);
    check("t4_pushpop_count", int'(bus.rx_count), 4);
    check("t4_pushpop_ovf", n_ovf, 1);
    pop_byte(8'h02);
    pop_byte(8'h03);
    pop_byte(8'h04);
    pop_byte(8'h06);

    // Timeout after start + 4 data bits.
    ferr_before = n_ferr;
    send_frame(8'h55, 1'b0, 1'b1, 5, -1, 1'b0);
    for (int k = 0; k < 9000 && n_ferr == ferr_before; k++) wait_cyc(1);
    check("t5_timeout_seen", n_ferr, ferr_before + 1);
    // pin fall -> strobe is 2 + FL = 6 cycles, then TIMEOUT = 8000 cycles
    check("t5_timeout_latency", ferr_cyc - last_fall_cyc, 8006);
    exp_ferr++;
    $display("timeout abort");
    wait_cyc(4);
    settled = 1'b1;
    send_frame(8'hAA, 1'b0, 1'b1, 11, -1, 1'b0);
    check("t5_after_data", int'(bus.rx_data), 8'hAA);
    pop_byte(8'hAA);

    // Glitches: idle, and inside a frame.
    ps2_clk = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("t6_idle_glitch_count", int'(bus.rx_count), 0);
    $display("idle glitch");
    send_frame(8'h3C, 1'b0, 1'b1, 11, 4, 1'b0);
    check("t6_frame_glitch_data", int'(bus.rx_data), 8'h3C);
    check("t6_frame_glitch_count", int'(bus.rx_count), 1);
    pop_byte(8'h3C);

    // Reset mid-frame with a byte already buffered.
    send_frame(8'h33, 1'b0, 1'b1, 11, -1, 1'b0);
    send_frame(8'h66, 1'b0, 1'b1, 3, -1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    $display("reset mid-frame");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_cyc(5);
    settled = 1'b1;
    send_frame(8'h77, 1'b0, 1'b1, 11, -1, 1'b0);
    check("t7_after_reset_data", int'(bus.rx_data), 8'h77);
    check("t7_after_reset_count", int'(bus.rx_count), 1);
    pop_byte(8'h77);

    wait_cyc(4);
    settled = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Core-side PS/2 receiver. Deserialises the ps2_kbd_clk/ps2_kbd_data (or mouse) stream driven by the io-controller interface block into bytes.
- Buffers received bytes in a small show-ahead FIFO for the core's keyboard/mouse logic.
- Runs entirely in the core clock domain: oversamples the slow PS/2 clock, filters it and edge-detects it.
- Flags parity, framing, timeout and overflow conditions.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered PS/2 clock changes state (1..15).
- TIMEOUT, 16'd8000: clk cycles without a filtered falling edge mid-frame before the frame is aborted.
- FIFO_BITS, 2: log2 of FIFO depth (default depth 4).

Ports:
- clk  in  1  core clock, ≥ 1 MHz; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock line, idle high, asynchronous to clk.
- ps2_data  in  1  PS/2 data line, asynchronous to clk.
- rx_rd  in  1  pop request; ignored when rx_valid=0.
- rx_data  out  8  head-of-FIFO byte (show-ahead); valid while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_count  out  FIFO_BITS+1  number of bytes held.
- parity_err  out  1  one-cycle pulse: frame discarded for bad parity.
- frame_err  out  1  one-cycle pulse: stop bit 0 or timeout abort.
- overflow  out  1  one-cycle pulse: good byte dropped, FIFO full.

Behaviour:
- Reset (async assert, sync release):
  - Sync flops and filtered clock = 1.
  - State = IDLE; shift register, bit counter and timeout counter = 0.
  - FIFO pointers = 0; rx_valid=0, rx_count=0, rx_data=0.
  - All error pulses = 0.
- Input sync: ps2_clk and ps2_data each pass through 2 flops.
- Clock filter:
  - A counter tracks how long the synced clk has differed from the filtered clk.
  - When FILTER_LEN consecutive samples differ, the filtered clk toggles and the counter clears.
  - Any matching sample clears the counter.
- Edge detect:
  - fall = filtered clk 1→0 registered transition, one-cycle strobe.
  - Data is sampled from the synced data on the fall cycle.
- Frame format: start(0), 8 data bits LSB first, odd parity (data ones + parity bit is odd), stop(1). Eleven falling edges per frame.
- State machine, advancing only on fall:
  - IDLE: data=0 → DATA, bit_cnt=0. data=1 → stay IDLE, no error.
  - DATA: shift right, new bit into [7], bit_cnt++. After the 8th bit → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: always return to IDLE.
    - data=0 → frame_err pulse, byte discarded.
    - Else parity bad → parity_err pulse, byte discarded.
    - Else push to FIFO.
    - Stop=0 with bad parity → frame_err only.
- Timeout:
  - The counter clears on every fall and while in IDLE; otherwise it increments.
  - Reaching TIMEOUT-1 outside IDLE → IDLE, frame_err pulse, partial byte discarded.
  - A timeout on the same cycle as a fall is not possible: fall clears the counter first.
- FIFO:
  - Push occurs in the cycle after the STOP fall is processed. rx_valid rises the next cycle, i.e. ≤ 2 + FILTER_LEN + 2 clks after the pin edge.
  - rx_rd with rx_valid pops: rptr++ and rx_data shows the next entry the following cycle.
  - Push when full and no pop: byte dropped, overflow pulse, contents unchanged.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle otherwise: count unchanged.
  - Pointers wrap modulo 2^FIFO_BITS. rx_count distinguishes full from empty.
  - rx_rd while empty: no effect, rx_count stays 0, no underflow.
- Glitches: a ps2_clk pulse shorter than FILTER_LEN clks produces no edge and no state change.
- Reset asserted mid-frame: immediate return to IDLE with the FIFO emptied. The next frame is received normally only after a clean start bit.

Test Plan:
- Send 0x1C (parity bit 0) at a 12 kHz PS/2 clock, clk=4 MHz → rx_valid=1, rx_data=0x1C, rx_count=1, no error pulses. Pulse rx_rd → rx_valid=0.
- Send 0xF0 then 0x5A back-to-back without reading → rx_count=2, rx_data=0xF0. After one rx_rd, rx_data=0x5A.
- Send 0x1C with parity bit 1 → one parity_err pulse, rx_count stays 0. Send 0x1C with stop=0 → one frame_err pulse, FIFO unchanged.
- Send 5 bytes 0x01..0x05 with FIFO_BITS=2 and no reads → rx_count=4, one overflow pulse on the 5th. Read out in order 0x01..0x04. Separately, push while full with rx_rd held in the same cycle → no overflow, count stays 4.
- Stop ps2_clk high after 4 data bits → frame_err pulse exactly TIMEOUT clks after the last fall, state IDLE. A following clean 0xAA is received correctly.
- Inject a 2-clk low glitch on ps2_clk while idle and within a frame → no state change, no error, next byte correct. Assert reset_n=0 mid-frame → all outputs 0 immediately.
